// File: rtl/zorro_cycle_ctl.sv
// zorro_cycle_ctl: Zorro III slave bus-cycle sequencer.
// Turns decoded RAM/autoconfig cycles into SLAVE_n/DTACK_n/DOE responses.
// Each RAM cycle becomes one level-request/pulse-acknowledge transaction
// toward the SDRAM controller.
// Optional feature macro: ZORRO_BUS_TIMEOUT_EN.
// When it is defined, a bus-error watchdog drives BERR_n.
// When it is undefined, BERR_n is tied high.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no cycle claimed; qualifiers sampled here only
// CFG_WAIT  | autoconfig cycle claimed, counting down to DTACK_n
// DS_WAIT   | RAM cycle claimed, waiting for any data strobe
// RAM_WAIT  | ram_req high, waiting for ram_ack
// ACK       | response driven, waiting for fcs to fall
// DRAIN     | bus side finished early; waiting for ram_ack to retire ram_req

module zorro_cycle_ctl #(
    parameter int SYNC_STAGES     = 2,
    parameter int CFG_WAIT_CYCLES = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       FCS_n,
    input  logic [3:0] DS_n,
    input  logic       READ,
    input  logic       ram_cycle,
    input  logic       autoconfig_cycle,
    output logic       ram_req,
    output logic       ram_write,
    output logic [3:0] ram_be,
    input  logic       ram_ack,
    output logic       SLAVE_n,
    output logic       DTACK_n,
    output logic       DOE,
    output logic       BERR_n,
    output logic       busy
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("zorro_cycle_ctl: SYNC_STAGES must be 2..3");
    end
    if (CFG_WAIT_CYCLES < 1 || CFG_WAIT_CYCLES > 15) begin : g_bad_cfg_wait
        $error("zorro_cycle_ctl: CFG_WAIT_CYCLES must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("zorro_cycle_ctl: TIMEOUT_CYCLES must be 1..255");
    end

    // The autoconfig wait is a down-counter: it is loaded on entry and the FSM leaves at zero.
    localparam logic [3:0] CFG_LOAD = 4'(CFG_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG_WAIT = 3'd1,
        ST_DS_WAIT  = 3'd2,
        ST_RAM_WAIT = 3'd3,
        ST_ACK      = 3'd4,
        ST_DRAIN    = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0]      fcs_sync;
    logic [SYNC_STAGES-1:0][3:0] ds_sync;
    logic                        fcs;
    logic [3:0]                  ds_s;
    logic                        ds_any;

    logic [3:0] cfg_cnt_q, cfg_cnt_d;
    logic       ram_req_q, ram_req_d;
    logic       ram_write_q, ram_write_d;
    logic [3:0] ram_be_q, ram_be_d;
    logic       slave_n_q, slave_n_d;
    logic       dtack_n_q, dtack_n_d;
    logic       doe_q, doe_d;
    logic       berr_n_q, berr_n_d;
    logic       tmo_hit;

    // Synchronise the asynchronous bus strobes; the flops reset to the inactive level.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            fcs_sync <= '1;
            ds_sync  <= '1;
        end else begin
            fcs_sync[0] <= FCS_n;
            ds_sync[0]  <= DS_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                fcs_sync[i] <= fcs_sync[i-1];
                ds_sync[i]  <= ds_sync[i-1];
            end
        end
    end

    assign fcs    = ~fcs_sync[SYNC_STAGES-1];
    assign ds_s   = ds_sync[SYNC_STAGES-1];
    assign ds_any = ~&ds_s;

`ifdef ZORRO_BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       tmo_run;

    // The watchdog only runs while the cycle is claimed and not yet answered.
    assign tmo_run = !slave_n_q && dtack_n_q && berr_n_q;
    assign tmo_hit = tmo_run && (tmo_cnt_q == 8'd0);

    // Watchdog down-counter: reloaded whenever SLAVE_n is released.
    always_ff @(posedge CLK) begin
        if (!RESET_n || slave_n_q) begin
            tmo_cnt_q <= TMO_LOAD;
        end else if (tmo_run && (tmo_cnt_q != 8'd0)) begin
            tmo_cnt_q <= tmo_cnt_q - 8'd1;
        end
    end

    assign BERR_n = berr_n_q;
`else
    assign tmo_hit = 1'b0;
    assign BERR_n  = 1'b1;
`endif

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            cfg_cnt_q   <= 4'd0;
            ram_req_q   <= 1'b0;
            ram_write_q <= 1'b0;
            ram_be_q    <= 4'd0;
            slave_n_q   <= 1'b1;
            dtack_n_q   <= 1'b1;
            doe_q       <= 1'b0;
            berr_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cfg_cnt_q   <= cfg_cnt_d;
            ram_req_q   <= ram_req_d;
            ram_write_q <= ram_write_d;
            ram_be_q    <= ram_be_d;
            slave_n_q   <= slave_n_d;
            dtack_n_q   <= dtack_n_d;
            doe_q       <= doe_d;
            berr_n_q    <= berr_n_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        cfg_cnt_d   = cfg_cnt_q;
        ram_req_d   = ram_req_q;
        ram_write_d = ram_write_q;
        ram_be_d    = ram_be_q;
        slave_n_d   = slave_n_q;
        dtack_n_d   = dtack_n_q;
        doe_d       = doe_q;
        berr_n_d    = berr_n_q;

        case (state_q)
            ST_IDLE: begin
                // An autoconfig cycle takes priority over a RAM cycle.
                if (fcs && autoconfig_cycle) begin
                    state_d   = ST_CFG_WAIT;
                    slave_n_d = 1'b0;
                    cfg_cnt_d = CFG_LOAD;
                end else if (fcs && ram_cycle) begin
                    state_d   = ST_DS_WAIT;
                    slave_n_d = 1'b0;
                end
            end

            ST_CFG_WAIT: begin
                if (!fcs) begin
                    state_d   = ST_IDLE;
                    slave_n_d = 1'b1;
                    dtack_n_d = 1'b1;
                    doe_d     = 1'b0;
                    berr_n_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d  = ST_ACK;
                    berr_n_d = 1'b0;
                end else if (cfg_cnt_q == 4'd0) begin
                    state_d   = ST_ACK;
                    dtack_n_d = 1'b0;
                    doe_d     = READ;
                end else begin
                    cfg_cnt_d = cfg_cnt_q - 4'd1;
                end
            end

            ST_DS_WAIT: begin
                if (!fcs) begin
                    state_d   = ST_IDLE;
                    slave_n_d = 1'b1;
                    dtack_n_d = 1'b1;
                    doe_d     = 1'b0;
                    berr_n_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d  = ST_ACK;
                    berr_n_d = 1'b0;
                end else if (ds_any) begin
                    state_d     = ST_RAM_WAIT;
                    ram_req_d   = 1'b1;
                    ram_write_d = ~READ;
                    ram_be_d    = ~ds_s;
                end
            end

            ST_RAM_WAIT: begin
                if (ram_ack) begin
                    ram_req_d = 1'b0;
                    if (fcs) begin
                        state_d   = ST_ACK;
                        dtack_n_d = 1'b0;
                        doe_d     = READ;
                    end else begin
                        state_d     = ST_IDLE;
                        slave_n_d   = 1'b1;
                        dtack_n_d   = 1'b1;
                        doe_d       = 1'b0;
                        berr_n_d    = 1'b1;
                        ram_be_d    = 4'd0;
                        ram_write_d = 1'b0;
                    end
                end else if (!fcs) begin
                    // The SDRAM transaction cannot be aborted; only the bus side is let go.
                    state_d   = ST_DRAIN;
                    slave_n_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d  = ST_DRAIN;
                    berr_n_d = 1'b0;
                end
            end

            ST_ACK: begin
                if (!fcs) begin
                    state_d     = ST_IDLE;
                    slave_n_d   = 1'b1;
                    dtack_n_d   = 1'b1;
                    doe_d       = 1'b0;
                    berr_n_d    = 1'b1;
                    ram_be_d    = 4'd0;
                    ram_write_d = 1'b0;
                end
            end

            ST_DRAIN: begin
                if (ram_ack) begin
                    ram_req_d   = 1'b0;
                    ram_be_d    = 4'd0;
                    ram_write_d = 1'b0;
                    // A bus error still in progress must hold BERR_n until the master lets go.
                    if (fcs && !berr_n_q) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d   = ST_IDLE;
                        slave_n_d = 1'b1;
                        dtack_n_d = 1'b1;
                        doe_d     = 1'b0;
                        berr_n_d  = 1'b1;
                    end
                end else if (!fcs) begin
                    slave_n_d = 1'b1;
                    berr_n_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ram_req   = ram_req_q;
    assign ram_write = ram_write_q;
    assign ram_be    = ram_be_q;
    assign SLAVE_n   = slave_n_q;
    assign DTACK_n   = dtack_n_q;
    assign DOE       = doe_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
